// File: rtl/word_capture_pkg.sv
// Shared types, widths and length/mask helpers for the word capture FIFO.
package word_capture_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WIDTH_W = 5;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned EXT_W   = DATA_W + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Width selector 0 means a full 32-bit word.
  function automatic logic [LEN_W-1:0] decode_length(input logic [WIDTH_W-1:0] width);
    return (width == '0) ? LEN_W'(DATA_W) : LEN_W'(width);
  endfunction

  // Ones in the low len bits; one extra bit lets len=32 yield all ones.
  function automatic logic [DATA_W-1:0] length_mask(input logic [LEN_W-1:0] len);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(1) << len;
    return DATA_W'(ext - EXT_W'(1));
  endfunction

endpackage

// File: rtl/word_capture_mem.sv
// Entry storage: synchronous write port, asynchronous read port, no reset.
module word_capture_mem
  import word_capture_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_entry,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_entry
);

  entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/word_capture_fifo.sv
// Captures deserializer words on store_strobe into a first-word-fall-through FIFO.
// Optional WORD_CAPTURE_FIFO_DROP_COUNT_EN adds a saturating dropped-word counter.
module word_capture_fifo
  import word_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH_W-1:0]       width,
  input  logic [DATA_W-1:0]        store_bits,
  input  logic                     store_strobe,
  output logic [DATA_W-1:0]        out_data,
  output logic [LEN_W-1:0]         out_width,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
  ,
  output logic [DROP_W-1:0]        drop_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [LEN_W-1:0] store_len;
  entry_t           wr_entry;
  entry_t           rd_entry;

  // Push/pop decisions; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full      = (level == LVL_W'(DEPTH));
    out_valid = (wr_ptr != rd_ptr);
    pop       = out_valid & out_ready;
    push      = store_strobe & (~full | pop);
    drop      = store_strobe & full & ~pop;
    store_len = decode_length(width);
    wr_entry.len  = store_len;
    wr_entry.data = store_bits & length_mask(store_len);
  end

  word_capture_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clock    (clock),
    .wr_en    (push),
    .wr_addr  (wr_ptr[PTR_W-1:0]),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr[PTR_W-1:0]),
    .rd_entry (rd_entry)
  );

  assign out_data  = out_valid ? rd_entry.data : '0;
  assign out_width = out_valid ? rd_entry.len  : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LVL_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LVL_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
  // Saturating drop counter; a drop coinciding with a clear restarts at one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clear_overflow) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (clear_overflow) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_word_capture_fifo.sv
// Directed and random stimulus for word_capture_fifo checked against a queue model.
module tb_word_capture_fifo;
  import word_capture_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [4:0]  width;
  logic [31:0] store_bits;
  logic        store_strobe;
  logic [31:0] out_data;
  logic [5:0]  out_width;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        clear_overflow;
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t      mq[$];
  logic        m_ovf;
  int unsigned m_dc;

  word_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .width          (width),
    .store_bits     (store_bits),
    .store_strobe   (store_strobe),
    .out_data       (out_data),
    .out_width      (out_width),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t model_entry(input logic [4:0] w, input logic [31:0] b);
    entry_t e;
    longint unsigned len;
    len    = (w == 5'd0) ? 32 : longint'(w);
    e.len  = 6'(len);
    e.data = 32'(longint'(b) % (64'd1 << len));
    return e;
  endfunction

  task automatic model_update(input logic s, input logic [4:0] w, input logic [31:0] b,
                              input logic r, input logic c);
    bit was_full;
    bit popped;
    bit dropped;
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() != 0) && r;
    dropped  = 1'b0;
    if (popped) void'(mq.pop_front());
    if (s) begin
      if (!was_full || popped) mq.push_back(model_entry(w, b));
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_dc  = c ? 1 : ((m_dc < 65535) ? m_dc + 1 : 65535);
    end else if (c) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    bit ev;
    ev = (mq.size() != 0);
    check({tag, "_valid"}, 32'(out_valid), 32'(ev));
    check({tag, "_data"},  out_data,  ev ? mq[0].data : 32'd0);
    check({tag, "_width"}, 32'(out_width), ev ? 32'(mq[0].len) : 32'd0);
    check({tag, "_level"}, 32'(level), mq.size());
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
    check({tag, "_dcnt"},  32'(drop_count), m_dc);
`endif
  endtask

  task automatic step(input string tag, input logic s, input logic [4:0] w,
                      input logic [31:0] b, input logic r, input logic c);
    store_strobe = s; width = w; store_bits = b; out_ready = r; clear_overflow = c;
    @(posedge clock);
    #1;
    model_update(s, w, b, r, c);
    store_strobe = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    compare_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
  endtask

  initial begin
    reset = 1'b1; width = '0; store_bits = '0; store_strobe = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    #3;
    compare_all("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Masked short word, then a full-width word
    step("t1", 1'b1, 5'd4, 32'hFFFF_FFF5, 1'b0, 1'b0);
    check("t1_const_data", out_data, 32'h5);
    check("t1_const_width", 32'(out_width), 32'd4);
    check("t1_const_level", 32'(level), 32'd1);
    step("t2", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("t2_const_data", out_data, 32'hDEAD_BEEF);
    check("t2_const_width", 32'(out_width), 32'd32);
    step("t2_drain", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    // Overfill with ready low, then read back in order
    for (int i = 0; i < DEPTH + 2; i++) begin
      step("t3_fill", 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
      check("t3_const_ovf", 32'(overflow), (i >= DEPTH) ? 32'd1 : 32'd0);
    end
    check("t3_const_level", 32'(level), 32'd8);
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
    check("t3_const_dcnt", 32'(drop_count), 32'd2);
`endif
    for (int i = 0; i < DEPTH; i++) step("t3_read", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step("t3_clear", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("t3_const_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++)
      step("t4_fill", 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
    step("t4_pushpop", 1'b1, 5'd12, 32'h1234_5ABC, 1'b1, 1'b0);
    check("t4_const_level", 32'(level), 32'd8);
    check("t4_const_ovf", 32'(overflow), 32'd0);

    // Drop, then drop coinciding with clear
    step("t5_drop", 1'b1, 5'd7, $urandom, 1'b0, 1'b0);
    step("t5_dropclr", 1'b1, 5'd9, $urandom, 1'b0, 1'b1);
    check("t5_const_ovf", 32'(overflow), 32'd1);
`ifdef WORD_CAPTURE_FIFO_DROP_COUNT_EN
    check("t5_const_dcnt", 32'(drop_count), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) step("t5_drain", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at level 5
    for (int i = 0; i < 5; i++)
      step("t6_fill", 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
    check("t6_const_level5", 32'(level), 32'd5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6_const_valid", 32'(out_valid), 32'd0);
    check("t6_const_level", 32'(level), 32'd0);
    check("t6_const_ovf", 32'(overflow), 32'd0);
    check("t6_const_data", out_data, 32'd0);
    compare_all("t6_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    step("t6_after", 1'b1, 5'd16, 32'hCAFE_F00D, 1'b0, 1'b0);
    check("t6_const_after", out_data, 32'h0000_F00D);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
